ram_march_tester: RTL and testbench

- Built-in self-test engine that drives one port of the team's 64x8 synchronous RAM (registered read, write-through q on write) as the memory-side initiator.
- Runs a fixed 4-element March test (address sweeps up and down, with a pattern and its complement).
- Compares read data and reports pass/fail, the first failing location, and an error count.
- Sits beside the RAM; a top-level mux hands the port to the tester while busy=1.

---
 rtl/ram_march_tester.sv | 215 +++++++++++++++++++++
 tb/tb_ram_march_tester.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ram_march_tester.sv
// March BIST engine for a 64x8 synchronous RAM port: a 4-element up/down sweep
// with pattern and complement, reporting error count and the first failing location.
module ram_march_tester #(
  parameter int                ADDR_W  = 6,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [7:0]        o_err_cnt,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_exp,
  output logic [DATA_W-1:0] o_fail_got
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0_W, S_M1_R, S_M1_W, S_M2_R, S_M2_W, S_M3_R, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] PAT_N     = ~PATTERN;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_we, w_we_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_pass, w_pass_nxt;
  logic [7:0]          r_err_cnt, w_err_nxt;
  logic [ADDR_W-1:0]   r_fail_addr, w_fail_addr_nxt;
  logic [DATA_W-1:0]   r_fail_exp, w_fail_exp_nxt;
  logic [DATA_W-1:0]   r_fail_got, w_fail_got_nxt;
  logic                r_chk_vld;
  logic [ADDR_W-1:0]   r_chk_addr;
  logic [DATA_W-1:0]   r_chk_exp;
  logic                w_clear, w_rd_issue, w_mis;
  logic [DATA_W-1:0]   w_rd_exp;

  // Next-state and next-port-operation logic; the registered mem_* are applied at the coming edge.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_we_nxt    = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_clear     = 1'b0;
    w_rd_issue  = 1'b0;
    w_rd_exp    = PATTERN;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_M0_W;
          w_addr_nxt  = ADDR_ZERO;
          w_we_nxt    = 1'b1;
          w_wdata_nxt = PATTERN;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_M0_W: begin
        if (r_addr == ADDR_MAX) begin
          w_state_nxt = S_M1_R;
          w_addr_nxt  = ADDR_ZERO;
        end else begin
          w_addr_nxt  = r_addr + ADDR_ONE;
          w_we_nxt    = 1'b1;
          w_wdata_nxt = PATTERN;
        end
      end
      S_M1_R: begin
        w_rd_issue  = 1'b1;
        w_rd_exp    = PATTERN;
        w_state_nxt = S_M1_W;
        w_we_nxt    = 1'b1;
        w_wdata_nxt = PAT_N;
      end
      S_M1_W: begin
        if (r_addr == ADDR_MAX) begin
          w_state_nxt = S_M2_R;
        end else begin
          w_state_nxt = S_M1_R;
          w_addr_nxt  = r_addr + ADDR_ONE;
        end
      end
      S_M2_R: begin
        w_rd_issue  = 1'b1;
        w_rd_exp    = PAT_N;
        w_state_nxt = S_M2_W;
        w_we_nxt    = 1'b1;
        w_wdata_nxt = PATTERN;
      end
      S_M2_W: begin
        if (r_addr == ADDR_ZERO) begin
          w_state_nxt = S_M3_R;
        end else begin
          w_state_nxt = S_M2_R;
          w_addr_nxt  = r_addr - ADDR_ONE;
        end
      end
      S_M3_R: begin
        w_rd_issue = 1'b1;
        w_rd_exp   = PATTERN;
        if (r_addr == ADDR_MAX) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_addr_nxt  = r_addr + ADDR_ONE;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_DONE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  assign w_mis = r_chk_vld && (i_mem_rdata != r_chk_exp);

  // Error accounting: count saturates, and only the first mismatch of a run is latched.
  always_comb begin
    w_err_nxt       = r_err_cnt;
    w_fail_addr_nxt = r_fail_addr;
    w_fail_exp_nxt  = r_fail_exp;
    w_fail_got_nxt  = r_fail_got;
    if (w_clear) begin
      w_err_nxt       = 8'd0;
      w_fail_addr_nxt = ADDR_ZERO;
      w_fail_exp_nxt  = {DATA_W{1'b0}};
      w_fail_got_nxt  = {DATA_W{1'b0}};
    end else if (w_mis) begin
      if (r_err_cnt != 8'hFF) begin
        w_err_nxt = r_err_cnt + 8'd1;
      end else begin
        w_err_nxt = r_err_cnt;
      end
      if (r_err_cnt == 8'd0) begin
        w_fail_addr_nxt = r_chk_addr;
        w_fail_exp_nxt  = r_chk_exp;
        w_fail_got_nxt  = i_mem_rdata;
      end else begin
        w_fail_addr_nxt = r_fail_addr;
      end
    end else begin
      w_err_nxt = r_err_cnt;
    end
    w_pass_nxt = w_done_nxt && (w_err_nxt == 8'd0);
  end

  // State, port and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= ADDR_ZERO;
      r_wdata     <= {DATA_W{1'b0}};
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_fail_addr <= ADDR_ZERO;
      r_fail_exp  <= {DATA_W{1'b0}};
      r_fail_got  <= {DATA_W{1'b0}};
      r_chk_vld   <= 1'b0;
      r_chk_addr  <= ADDR_ZERO;
      r_chk_exp   <= {DATA_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_we        <= w_we_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_err_cnt   <= w_err_nxt;
      r_fail_addr <= w_fail_addr_nxt;
      r_fail_exp  <= w_fail_exp_nxt;
      r_fail_got  <= w_fail_got_nxt;
      r_chk_vld   <= w_rd_issue;
      r_chk_addr  <= r_addr;
      r_chk_exp   <= w_rd_exp;
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_we    = r_we;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_cnt   = r_err_cnt;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_exp  = r_fail_exp;
  assign o_fail_got  = r_fail_got;

endmodule

// File: tb/tb_ram_march_tester.sv
// Directed bench for ram_march_tester with a 64x8 RAM model that can inject
// stuck-bit, stuck-data and address-alias faults.
module tb_ram_march_tester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [5:0] fail_addr;
  logic [7:0] fail_exp, fail_got;

  int n_total = 0;
  int n_bad   = 0;
  int fault   = 0;

  logic [7:0] mem [64];
  logic [7:0] q_r = 8'h00;
  logic [5:0] idx_s;
  logic [7:0] wd_s;

  ram_march_tester dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt),
    .o_fail_addr(fail_addr), .o_fail_exp(fail_exp), .o_fail_got(fail_got)
  );

  always #5 clk = ~clk;

  assign idx_s     = (fault == 3) ? {1'b0, mem_addr[4:0]} : mem_addr;
  assign wd_s      = (fault == 1 && mem_addr == 6'd17) ? (mem_wdata & 8'hF7) : mem_wdata;
  assign mem_rdata = (fault == 2) ? 8'h00 : q_r;

  // RAM model: registered read, write-through q.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[idx_s] <= wd_s;
      q_r        <= wd_s;
    end else begin
      q_r <= mem[idx_s];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int repulse_at, output int busy_cyc, output int we_cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0;
    we_cyc   = 0;
    for (int k = 0; k < 1000; k++) begin
      if (done) break;
      if (busy) busy_cyc++;
      if (mem_we) we_cyc++;
      start = (busy_cyc == repulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int bc, wc, bad_cells, we_after;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {16'd0, busy, done, pass, err_cnt, fail_addr, fail_exp, fail_got, mem_we, mem_addr, mem_wdata},
        64'd0);
    rst_n = 1'b1;

    // clean RAM
    fault = 0;
    run(-1, bc, wc);
    chk("clean_busy_cycles", 64'(bc), 64'd385);
    chk("clean_write_cycles", 64'(wc), 64'd192);
    chk("clean_pass", {62'd0, busy, pass}, 64'd1);
    chk("clean_err_cnt", 64'(err_cnt), 64'd0);
    bad_cells = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 8'h55) bad_cells++;
    chk("clean_ram_contents", 64'(bad_cells), 64'd0);

    // bit 3 of address 17 stuck at 0
    fault = 1;
    run(-1, bc, wc);
    chk("stuck_bit_err_cnt", 64'(err_cnt), 64'd1);
    chk("stuck_bit_fail_info", {41'd0, pass, fail_addr, fail_exp, fail_got}, {41'd0, 1'b0, 6'd17, 8'hAA, 8'hA2});

    // address bit 5 ignored
    fault = 3;
    run(-1, bc, wc);
    chk("alias_fail_addr", 64'(fail_addr), 64'd32);
    chk("alias_fail_data", {48'd0, fail_exp, fail_got}, {48'd0, 8'h55, 8'hAA});
    chk("alias_flags", {62'd0, pass, (err_cnt != 8'd0)}, 64'd1);

    // start re-pulsed mid-run is ignored
    fault = 0;
    run(50, bc, wc);
    chk("repulse_busy_cycles", 64'(bc), 64'd385);
    chk("repulse_pass", 64'(pass), 64'd1);

    // reset at cycle 100 of a run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("abort_was_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero",
        {16'd0, busy, done, pass, err_cnt, fail_addr, fail_exp, fail_got, mem_we, mem_addr, mem_wdata},
        64'd0);
    we_after = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (mem_we) we_after++;
    end
    chk("abort_no_writes", 64'(we_after + (busy ? 1 : 0) + (done ? 1 : 0)), 64'd0);
    run(-1, bc, wc);
    chk("after_abort_busy_cycles", 64'(bc), 64'd385);
    chk("after_abort_pass", 64'(pass), 64'd1);

    // data stuck at 00, with start held high through DONE
    fault = 2;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_err_cnt", 64'(err_cnt), 64'd192);
    chk("zero_fail_info", {41'd0, pass, fail_addr, fail_exp, fail_got}, {41'd0, 1'b0, 6'd0, 8'h55, 8'h00});
    @(negedge clk);
    chk("restart_state", {53'd0, busy, done, pass, err_cnt}, {53'd0, 1'b1, 1'b0, 1'b0, 8'd0});
    start = 1'b0;
    fault = 0;
    for (int k = 0; k < 1000; k++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("restart_pass", {62'd0, done, pass}, 64'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
